// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// Runs one memory transaction per accepted request, sitting right after the
// address bus mux. A request latches the selected address, store data and
// access type, raises exactly one memory strobe until the memory answers with
// mem_ready, returns the fetched instruction or load data in holding
// registers, and then pulses done for one cycle. Only one transaction can be
// outstanding at a time.
//
// Optional build macro: MEM_TIMEOUT_EN
//   When defined, an access that sees no mem_ready for TIMEOUT_CYCLES ACCESS
//   cycles is abandoned. done is still pulsed, err is raised with it, and the
//   data registers are left untouched. When undefined, ACCESS waits forever
//   and err is tied low.
//
// Ports:
//   clk, reset_n             rising-edge clock, asynchronous active-low reset
//   req_valid / req_ready    request handshake from/to the control unit
//   sel_add_bus              1 = data access (LDR/STR), 0 = instruction fetch
//   is_store                 1 = STR write (only meaningful for data access)
//   addr_in, wr_data         address and store data for the request
//   mem_addr, mem_wdata      address and write data presented to memory
//   mem_rd_en, mem_wr_en     mutually exclusive memory strobes
//   mem_rdata, mem_ready     read data and completion from memory
//   instr_out, load_data     last fetched instruction / last load result
//   done                     one-cycle completion pulse
//   err                      timeout flag, raised together with done

module mem_access_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              sel_add_bus,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              err
);

    // A zero or negative limit would make the timeout counter meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_q,   sel_d;
    logic              store_q, store_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_q,  load_d;
    logic              is_write;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    // The access type is fixed at acceptance, so the strobe choice comes
    // purely from the latched request bits and cannot glitch on input changes.
    assign is_write  = sel_q & store_q;

    // Strobes decode straight from the state flop so an asynchronous reset
    // drops them at once, without waiting for a clock edge.
    assign mem_wr_en = (state_q == S_ACCESS) &  is_write;
    assign mem_rd_en = (state_q == S_ACCESS) & ~is_write;
    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign instr_out = instr_q;
    assign load_data = load_q;

`ifdef MEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and register update logic. mem_ready is only looked at in
    // ACCESS, and a success in the same cycle the limit is reached wins over
    // the timeout.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        store_d = store_q;
        instr_d = instr_q;
        load_d  = load_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = addr_in;
                    wdata_d = wr_data;
                    sel_d   = sel_add_bus;
                    store_d = is_store;
                    state_d = S_ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    if (!sel_q) begin
                        instr_d = mem_rdata;
                    end else if (!store_q) begin
                        load_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset so
    // an interrupted transaction leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            store_q <= 1'b0;
            instr_q <= '0;
            load_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            store_q <= store_d;
            instr_q <= instr_d;
            load_q  <= load_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule
